// File: rtl/nb_info_writer_pkg.sv
// nb_info_writer_pkg: shared FSM state encoding and neighbour info word field layout
package nb_info_writer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;
  // info word layout: {mv_idx, ref_idx, pred_mode}, LSB first
  localparam int PRED_MODE_LSB = 0;
  localparam int PRED_MODE_W   = 6;
  localparam int REF_IDX_LSB   = PRED_MODE_LSB + PRED_MODE_W;
  localparam int REF_IDX_W     = 4;
  localparam int MV_IDX_LSB    = REF_IDX_LSB + REF_IDX_W;
  localparam int MV_IDX_W      = 6;
  localparam int INFO_W        = MV_IDX_LSB + MV_IDX_W;
  function automatic logic [INFO_W-1:0] pack_info(
    input logic [PRED_MODE_W-1:0] pred_mode,
    input logic [REF_IDX_W-1:0]   ref_idx,
    input logic [MV_IDX_W-1:0]    mv_idx
  );
    return {mv_idx, ref_idx, pred_mode};
  endfunction
endpackage

// File: rtl/nb_info_writer_if.sv
// nb_info_writer_if: request handshake plus up/left neighbour dram write ports
interface nb_info_writer_if #(
  parameter int UP_BITS   = 8,
  parameter int LEFT_BITS = 4,
  parameter int DATA_BITS = 16
);
  logic                 stall;
  logic                 start;
  logic [UP_BITS-1:0]   x4;
  logic [LEFT_BITS-1:0] y4;
  logic [3:0]           w4_m1;
  logic [3:0]           h4_m1;
  logic [DATA_BITS-1:0] info;
  logic                 busy;
  logic                 done;
  logic                 up_en;
  logic                 up_we;
  logic [UP_BITS-1:0]   up_addr;
  logic [DATA_BITS-1:0] up_data;
  logic                 left_en;
  logic                 left_we;
  logic [LEFT_BITS-1:0] left_addr;
  logic [DATA_BITS-1:0] left_data;
  modport master (
    output stall, start, x4, y4, w4_m1, h4_m1, info,
    input  busy, done, up_en, up_we, up_addr, up_data,
    input  left_en, left_we, left_addr, left_data
  );
  modport slave (
    input  stall, start, x4, y4, w4_m1, h4_m1, info,
    output busy, done, up_en, up_we, up_addr, up_data,
    output left_en, left_we, left_addr, left_data
  );
endinterface

// File: rtl/nb_info_writer.sv
// nb_info_writer: writes one PU's info word along its up and left edges into the neighbour drams.
// Define NB_LEFT_RANGE_CHECK_EN to suppress left writes past the CTB bottom and flag them on err.
module nb_info_writer
  import nb_info_writer_pkg::*;
#(
  parameter int UP_BITS   = 8,
  parameter int LEFT_BITS = 4,
  parameter int DATA_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  nb_info_writer_if.slave bus
`ifdef NB_LEFT_RANGE_CHECK_EN
  ,
  output logic err
`endif
);
  state_t               state, state_nx;
  logic [3:0]           cnt, w_q, h_q, span;
  logic [UP_BITS-1:0]   x_q;
  logic [LEFT_BITS-1:0] y_q;
  logic [DATA_BITS-1:0] info_q;
  logic                 accept, active, last, up_wr, left_wr;
  assign accept = (state == IDLE) && bus.start && !bus.stall;
  assign active = (state == WRITE) && !bus.stall;
  assign span   = (w_q > h_q) ? w_q : h_q;
  assign last   = active && (cnt == span);
  always_comb begin
    state_nx = state;
    state_nx = accept ? WRITE : last ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      w_q    <= '0;
      h_q    <= '0;
      info_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= '0;
        x_q    <= bus.x4;
        y_q    <= bus.y4;
        w_q    <= bus.w4_m1;
        h_q    <= bus.h4_m1;
        info_q <= bus.info;
      end else if (active) begin
        cnt <= cnt + 4'd1;
      end
    end
  end
  assign up_wr = active && (cnt <= w_q);
`ifdef NB_LEFT_RANGE_CHECK_EN
  // sums carry extra headroom so a row past the CTB bottom is visible instead of wrapping
  logic [LEFT_BITS+4:0] left_sum, req_sum;
  assign left_sum = (LEFT_BITS+5)'(y_q) + (LEFT_BITS+5)'(cnt);
  assign req_sum  = (LEFT_BITS+5)'(bus.y4) + (LEFT_BITS+5)'(bus.h4_m1);
  assign left_wr  = active && (cnt <= h_q) && ((left_sum >> LEFT_BITS) == '0);
  assign bus.left_addr = left_sum[LEFT_BITS-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (accept && ((req_sum >> LEFT_BITS) != '0)) err <= 1'b1;
  end
`else
  assign left_wr  = active && (cnt <= h_q);
  assign bus.left_addr = y_q + LEFT_BITS'(cnt);
`endif
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.up_en     = up_wr;
  assign bus.up_we     = up_wr;
  assign bus.up_addr   = x_q + UP_BITS'(cnt);
  assign bus.up_data   = info_q;
  assign bus.left_en   = left_wr;
  assign bus.left_we   = left_wr;
  assign bus.left_data = info_q;
endmodule

// File: tb/tb_nb_info_writer.sv
// tb_nb_info_writer: table-driven and randomized checks of nb_info_writer against a queue/array model
module tb_nb_info_writer;
  import nb_info_writer_pkg::*;
  localparam int UB = 8;
  localparam int LB = 4;
  localparam int DB = 16;
  localparam int UN = 2**UB;
  localparam int LN = 2**LB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  nb_info_writer_if #(.UP_BITS(UB), .LEFT_BITS(LB), .DATA_BITS(DB)) bus();
`ifdef NB_LEFT_RANGE_CHECK_EN
  logic err;
  nb_info_writer #(.UP_BITS(UB), .LEFT_BITS(LB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err(err));
`else
  nb_info_writer #(.UP_BITS(UB), .LEFT_BITS(LB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif
  int errors = 0;
  int checks = 0;
  logic [DB-1:0] up_mem[UN], left_mem[LN], exp_up[UN], exp_left[LN];
  bit up_touch[UN], left_touch[LN];
  int up_q[$], left_q[$], exp_uq[$], exp_lq[$];
  bit err_exp = 1'b0;
  always @(posedge clk) begin
    if (bus.up_we) begin
      up_q.push_back(int'(bus.up_addr));
      up_mem[bus.up_addr] <= bus.up_data;
    end
    if (bus.left_we) begin
      left_q.push_back(int'(bus.left_addr));
      left_mem[bus.left_addr] <= bus.left_data;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference: the PU covers columns x..x+w and rows y..y+h of the neighbour buffers
  task automatic model(input int x, input int y, input int w, input int h, input logic [DB-1:0] inf);
    exp_uq.delete();
    exp_lq.delete();
    for (int i = 0; i <= w; i++) begin
      int a;
      a = (x + i) % UN;
      exp_uq.push_back(a);
      exp_up[a] = inf;
      up_touch[a] = 1'b1;
    end
    for (int i = 0; i <= h; i++) begin
      int a;
      a = y + i;
`ifdef NB_LEFT_RANGE_CHECK_EN
      if (a >= LN) begin
        err_exp = 1'b1;
        continue;
      end
`endif
      a = a % LN;
      exp_lq.push_back(a);
      exp_left[a] = inf;
      left_touch[a] = 1'b1;
    end
  endtask
  task automatic cmp_state(input string nm);
    int mu, ml, mm;
    mu = 0;
    ml = 0;
    mm = 0;
    chk({nm, ":up_n"}, up_q.size(), exp_uq.size());
    chk({nm, ":left_n"}, left_q.size(), exp_lq.size());
    for (int i = 0; i < up_q.size() && i < exp_uq.size(); i++) if (up_q[i] != exp_uq[i]) mu++;
    for (int i = 0; i < left_q.size() && i < exp_lq.size(); i++) if (left_q[i] != exp_lq[i]) ml++;
    chk({nm, ":up_seq"}, mu, 0);
    chk({nm, ":left_seq"}, ml, 0);
    for (int i = 0; i < UN; i++) if (up_touch[i] && up_mem[i] !== exp_up[i]) mm++;
    for (int i = 0; i < LN; i++) if (left_touch[i] && left_mem[i] !== exp_left[i]) mm++;
    chk({nm, ":mem"}, mm, 0);
`ifdef NB_LEFT_RANGE_CHECK_EN
    chk({nm, ":err"}, err, err_exp);
`endif
  endtask
  task automatic run(input int x, input int y, input int w, input int h, input logic [DB-1:0] inf,
                     input logic [31:0] mask, input bit poke, input string nm);
    int cyc, s, m;
    bit fin;
    up_q.delete();
    left_q.delete();
    model(x, y, w, h, inf);
    m = (w > h) ? w : h;
    @(negedge clk);
    bus.start = 1'b1;
    bus.stall = 1'b0;
    bus.x4 = UB'(x);
    bus.y4 = LB'(y);
    bus.w4_m1 = 4'(w);
    bus.h4_m1 = 4'(h);
    bus.info = inf;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x4 = UB'($urandom);
    bus.y4 = LB'($urandom);
    bus.w4_m1 = 4'($urandom);
    bus.h4_m1 = 4'($urandom);
    bus.info = DB'($urandom);
    chk({nm, ":busy"}, bus.busy, 1);
    cyc = 1;
    s = 0;
    fin = 1'b0;
    while (cyc < 300) begin
      if (bus.done) begin
        fin = 1'b1;
        break;
      end
      bus.start = poke && (cyc == 2);
      bus.stall = (cyc <= 32) ? mask[cyc-1] : 1'b0;
      if (bus.stall) begin
        s++;
        #1;
        chk({nm, ":stall_we"}, {bus.up_we, bus.left_we}, 0);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    chk({nm, ":finished"}, fin, 1);
    chk({nm, ":cycles"}, cyc, m + 2 + s);
    @(negedge clk);
    chk({nm, ":done_pulse"}, {bus.done, bus.busy}, 0);
    cmp_state(nm);
  endtask
  typedef struct {
    int x, y, w, h;
    logic [DB-1:0] inf;
    logic [31:0] mask;
    bit poke;
    string nm;
  } vec_t;
  vec_t tv[7];
  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.x4 = '0;
    bus.y4 = '0;
    bus.w4_m1 = '0;
    bus.h4_m1 = '0;
    bus.info = '0;
    #3;
    chk("reset_outs", {bus.busy, bus.done, bus.up_we, bus.up_en, bus.left_we, bus.left_en}, 0);
`ifdef NB_LEFT_RANGE_CHECK_EN
    chk("reset_err", err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tv[0] = '{10, 2, 3, 1, 16'hA5C3, 32'h0, 1'b0, "basic"};
    tv[1] = '{5, 7, 0, 0, 16'h1234, 32'h0, 1'b0, "pu4x4"};
    tv[2] = '{20, 9, 3, 0, 16'hBEEF, 32'hE, 1'b0, "stall3"};
    tv[3] = '{254, 3, 3, 2, 16'h0F0F, 32'h0, 1'b1, "wrap_poke"};
    tv[4] = '{0, 14, 0, 3, 16'h7E57, 32'h0, 1'b0, "left_edge"};
    tv[5] = '{100, 0, 15, 15, pack_info(6'd26, 4'd2, 6'd9), 32'h5, 1'b0, "max"};
    tv[6] = '{50, 5, 1, 9, 16'hC001, 32'h0, 1'b0, "tall"};
    for (int i = 0; i < 7; i++) run(tv[i].x, tv[i].y, tv[i].w, tv[i].h, tv[i].inf, tv[i].mask, tv[i].poke, tv[i].nm);
    // asynchronous reset in the middle of a write burst
    up_q.delete();
    left_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.x4 = 8'd40;
    bus.y4 = 4'd4;
    bus.w4_m1 = 4'd5;
    bus.h4_m1 = 4'd5;
    bus.info = 16'h5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outs", {bus.busy, bus.done, bus.up_we, bus.left_we}, 0);
    exp_uq.delete();
    exp_lq.delete();
    exp_uq.push_back(40);
    exp_lq.push_back(4);
    exp_up[40] = 16'h5A5A;
    exp_left[4] = 16'h5A5A;
    up_touch[40] = 1'b1;
    left_touch[4] = 1'b1;
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", bus.busy, 0);
    cmp_state("midrst");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] mk;
      mk = $urandom & $urandom & 32'h0000FFFF;
      run(int'($urandom_range(UN - 1)), int'($urandom_range(LN - 1)), int'($urandom_range(15)),
          int'($urandom_range(15)), pack_info(6'($urandom), 4'($urandom), 6'($urandom)), mk,
          bit'($urandom_range(1)), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
